// File: rtl/sar_adc_pkg.sv
// Shared types and helpers for the multi-channel SAR ADC model.
// Reference conversion functions let checkers compute ideal codes.
package sar_adc_pkg;

    typedef enum logic {
        IDLE = 1'b0,
        CONV = 1'b1
    } state_t;

    typedef struct packed {
        logic               ovr;
        logic signed [15:0] code;
    } ideal_t;

    function automatic real code_to_real(input int code, input int nbits, input real vref);
        return real'(code) * vref / real'(1 << (nbits - 1));
    endfunction

    function automatic ideal_t ideal_code(input real v, input int nbits, input real vref);
        ideal_t r;
        real    s;
        real    hi;
        real    lo;
        s     = $floor(v * real'(1 << (nbits - 1)) / vref);
        hi    = real'((1 << (nbits - 1)) - 1);
        lo    = -real'(1 << (nbits - 1));
        r.ovr = (v >= vref) || (v < -vref);
        if (s > hi) s = hi;
        if (s < lo) s = lo;
        r.code = 16'($rtoi(s));
        return r;
    endfunction

endpackage

// File: rtl/sar_bit_engine.sv
// Sample-and-hold plus bit-serial SAR: go samples vin, then one bit per edge MSB first.
// Latency: result on the NBITS-th edge after go; fin flags that edge. No backpressure.
module sar_bit_engine
    import sar_adc_pkg::*;
#(
    parameter int  NBITS = 8,
    parameter real VREF  = 1.0
) (
    input  logic                    clk,
    input  logic                    rst,
    input  logic                    go,
    input  real                     vin,
    output logic signed [NBITS-1:0] res,
    output logic                    ovr,
    output logic                    fin
);

    localparam int  IW     = (NBITS > 2) ? $clog2(NBITS) : 1;
    localparam real HALF_R = real'(2 ** (NBITS - 1));

    real              hold;
    real              dac;
    logic [NBITS-1:0] u;
    logic [NBITS-1:0] one_hot;
    logic [NBITS-1:0] trial;
    logic [NBITS-1:0] u_next;
    logic [IW-1:0]    idx;
    logic             active;

    // Trial code in offset binary compared against the held sample.
    always_comb begin
        one_hot      = '0;
        one_hot[idx] = 1'b1;
        trial        = u | one_hot;
        dac          = (real'(trial) - HALF_R) * VREF / HALF_R;
        u_next       = (hold >= dac) ? trial : u;
    end

    assign fin = active && (idx == '0);

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            hold   <= 0.0;
            u      <= '0;
            idx    <= '0;
            active <= 1'b0;
            res    <= '0;
            ovr    <= 1'b0;
        end else if (go) begin
            hold   <= vin;
            u      <= '0;
            idx    <= IW'(NBITS - 1);
            active <= 1'b1;
        end else if (active) begin
            u <= u_next;
            if (idx == '0) begin
                active <= 1'b0;
                res    <= {~u_next[NBITS-1], u_next[NBITS-2:0]};
                ovr    <= (hold >= VREF) || (hold < -VREF);
            end else begin
                idx <= idx - 1'b1;
            end
        end
    end

endmodule

// File: rtl/sar_adc_mc.sv
// Multi-channel SAR ADC model: channel mux, scan sequencer, start/busy/done handshake.
// Latency: done NBITS edges after accept; scan spaces channels NBITS+1 apart. Start ignored while busy.
module sar_adc_mc
    import sar_adc_pkg::*;
#(
    parameter int  NBITS = 8,
    parameter int  NCH   = 4,
    parameter real VREF  = 1.0,
    parameter int  CH_W  = (NCH > 1) ? $clog2(NCH) : 1
) (
    input  logic                    clk,
    input  logic                    rst,
    input  logic                    start,
    input  logic                    scan,
    input  logic [CH_W-1:0]         ch_sel,
    input  real                     ana_in [NCH],
    output logic                    busy,
    output logic                    done,
    output logic                    eos,
    output logic signed [NBITS-1:0] dout,
    output logic [CH_W-1:0]         dout_ch,
    output logic                    ovr
);

    state_t          state;
    state_t          state_nxt;
    logic [CH_W-1:0] ch;
    logic [CH_W-1:0] ch_mux;
    logic            scan_q;
    logic            resample;
    logic            legal;
    logic            accept;
    logic            go;
    logic            fin;
    logic            last_ch;
    real             vin;

    assign legal   = scan || (32'(ch_sel) < NCH);
    assign accept  = (state == IDLE) && start && legal;
    assign go      = accept || resample;
    assign ch_mux  = accept ? (scan ? '0 : ch_sel) : ch;
    assign vin     = ana_in[ch_mux];
    assign last_ch = (32'(ch) == NCH - 1);
    assign busy    = (state == CONV);

    always_comb begin
        state_nxt = state;
        case (state)
            IDLE:    if (accept) state_nxt = CONV;
            CONV:    if (fin && (!scan_q || last_ch)) state_nxt = IDLE;
            default: state_nxt = IDLE;
        endcase
    end

    // In scan mode the next channel is sampled one edge after each done.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state    <= IDLE;
            ch       <= '0;
            scan_q   <= 1'b0;
            resample <= 1'b0;
            done     <= 1'b0;
            eos      <= 1'b0;
            dout_ch  <= '0;
        end else begin
            state    <= state_nxt;
            done     <= fin;
            eos      <= fin && (!scan_q || last_ch);
            resample <= fin && scan_q && !last_ch;
            if (accept) begin
                ch     <= ch_mux;
                scan_q <= scan;
            end
            if (fin) begin
                dout_ch <= ch;
                if (scan_q && !last_ch) ch <= ch + 1'b1;
            end
        end
    end

    sar_bit_engine #(
        .NBITS (NBITS),
        .VREF  (VREF)
    ) u_engine (
        .clk  (clk),
        .rst  (rst),
        .go   (go),
        .vin  (vin),
        .res  (dout),
        .ovr  (ovr),
        .fin  (fin)
    );

endmodule
